// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: shared definitions for the stack command sequencer.
//   - default DATA_WIDTH / DEPTH / POP_LATENCY constants
//   - command op encodings and the sequencer state enum
//   - cnt_width(): width of a counter that must hold values 0..n-1
package stack_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_DEPTH       = 15;
    localparam int unsigned DEF_POP_LATENCY = 2;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Sequencer states; REPUSH is only reachable when peek is built in
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        POP_WAIT = 2'b01,
        REPUSH   = 2'b10,
        RESP     = 2'b11
    } state_e;

    // Bits needed to count 0..n-1 (never less than one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stack_seq_level.sv
// stack_seq_level: up/down occupancy counter for the LIFO stack.
//   clk, reset_n : clock, async active-low reset
//   inc, dec     : single-cycle count up / count down requests
//   level        : registered occupancy
//   full_c       : level == DEPTH (combinational from the register)
//   empty_c      : level == 0     (combinational from the register)
module stack_seq_level
    import stack_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned LEVEL_W = $clog2(DEF_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inc,
    input  logic               dec,
    output logic [LEVEL_W-1:0] level,
    output logic               full_c,
    output logic               empty_c
);

    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;

    // Next occupancy; simultaneous inc and dec cancel out
    always_comb begin
        level_d = level_q;
        if (inc && !dec) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (dec && !inc) begin
            level_d = level_q - LEVEL_W'(1);
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level   = level_q;
    assign full_c  = (level_q == LEVEL_W'(DEPTH));
    assign empty_c = (level_q == '0);

endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: command front-end for the LIFO stack.
// Accepts push/pop/peek commands over cmd valid/ready, drives one-cycle
// stack strobes, rejects overflow/underflow up front, waits out the stack
// read latency and returns one response per command over rsp valid/ready.
//
// Build option: define STACK_SEQ_PEEK_EN to enable op 10 (peek = pop then
// re-push of the same byte). Without it op 10 is rejected like op 11.
//
// Ports:
//   clk, reset_n          : clock, async active-low reset (shared with stack)
//   cmd_valid/cmd_ready   : command handshake; cmd_op 00 push 01 pop 10 peek
//   cmd_op, cmd_data      : opcode and push payload
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data, rsp_err     : popped/peeked/echoed byte (0 on error), reject flag
//   stk_push, stk_pop     : one-cycle strobes to the stack
//   stk_data              : push data, valid with stk_push
//   stk_rdata             : stack read data, POP_LATENCY after pop sample
//   level                 : current occupancy
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned POP_LATENCY = DEF_POP_LATENCY
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [DATA_WIDTH-1:0]        cmd_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [DATA_WIDTH-1:0]        stk_data,
    input  logic [DATA_WIDTH-1:0]        stk_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);
    // Counter spans the POP_LATENCY+1 cycles spent in POP_WAIT
    localparam int unsigned CNT_W   = cnt_width(POP_LATENCY + 1);

    state_e                 state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q,  rsp_data_d;
    logic                   rsp_err_q,   rsp_err_d;
    logic                   stk_push_q,  stk_push_d;
    logic                   stk_pop_q,   stk_pop_d;
    logic [DATA_WIDTH-1:0]  stk_data_q,  stk_data_d;
`ifdef STACK_SEQ_PEEK_EN
    logic                   peek_q,      peek_d;
`endif

    logic                   lvl_inc_c;
    logic                   lvl_dec_c;
    logic                   full_c;
    logic                   empty_c;
    logic                   reject_c;

    // Occupancy tracking; only moves on the accept edge
    stack_seq_level #(
        .DEPTH   (DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_level (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (lvl_inc_c),
        .dec     (lvl_dec_c),
        .level   (level),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        stk_push_d  = 1'b0;
        stk_pop_d   = 1'b0;
        stk_data_d  = stk_data_q;
        lvl_inc_c   = 1'b0;
        lvl_dec_c   = 1'b0;
        reject_c    = 1'b0;
`ifdef STACK_SEQ_PEEK_EN
        peek_d      = peek_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full_c) begin
                                reject_c = 1'b1;
                            end else begin
                                stk_push_d  = 1'b1;
                                stk_data_d  = cmd_data;
                                lvl_inc_c   = 1'b1;
                                rsp_data_d  = cmd_data;
                                rsp_err_d   = 1'b0;
                                rsp_valid_d = 1'b1;
                                state_d     = RESP;
                            end
                        end
                        OP_POP: begin
                            if (empty_c) begin
                                reject_c = 1'b1;
                            end else begin
                                stk_pop_d = 1'b1;
                                lvl_dec_c = 1'b1;
                                cnt_d     = '0;
                                state_d   = POP_WAIT;
`ifdef STACK_SEQ_PEEK_EN
                                peek_d    = 1'b0;
`endif
                            end
                        end
`ifdef STACK_SEQ_PEEK_EN
                        // Peek pops without touching level; the byte is
                        // pushed back after capture so net occupancy is 0
                        OP_PEEK: begin
                            if (empty_c) begin
                                reject_c = 1'b1;
                            end else begin
                                stk_pop_d = 1'b1;
                                cnt_d     = '0;
                                peek_d    = 1'b1;
                                state_d   = POP_WAIT;
                            end
                        end
`endif
                        default: begin
                            reject_c = 1'b1;
                        end
                    endcase
                end
            end

            // Wait until stk_rdata is valid, then capture it
            POP_WAIT: begin
                if (cnt_q == CNT_W'(POP_LATENCY)) begin
                    rsp_data_d  = stk_rdata;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
`ifdef STACK_SEQ_PEEK_EN
                    if (peek_q) begin
                        stk_push_d = 1'b1;
                        stk_data_d = stk_rdata;
                        state_d    = REPUSH;
                    end else begin
                        state_d    = RESP;
                    end
`else
                    state_d     = RESP;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef STACK_SEQ_PEEK_EN
            // Re-push cycle; the response is already valid here
            REPUSH: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
`endif

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Rejected command: no strobe, level untouched, error response
        if (reject_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = RESP;
        end

        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            stk_push_q  <= 1'b0;
            stk_pop_q   <= 1'b0;
            stk_data_q  <= '0;
`ifdef STACK_SEQ_PEEK_EN
            peek_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            stk_push_q  <= stk_push_d;
            stk_pop_q   <= stk_pop_d;
            stk_data_q  <= stk_data_d;
`ifdef STACK_SEQ_PEEK_EN
            peek_q      <= peek_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign stk_push  = stk_push_q;
    assign stk_pop   = stk_pop_q;
    assign stk_data  = stk_data_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer with a behavioural 2-cycle-latency stack.
module tb_stack_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_data;
    logic [7:0] stk_rdata;
    logic [3:0] level;

    always #5 clk = ~clk;

    stack_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_data  (stk_data),
        .stk_rdata (stk_rdata),
        .level     (level)
    );

    // Stack model: pop sampled at edge E, data valid only in the cycle
    // after edge E+1 (two edges of latency), garbage otherwise.
    logic [7:0] mem [16];
    logic [4:0] sp;
    logic       v1, v2;
    logic [7:0] d1, d2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            if (stk_push) begin
                mem[sp[3:0]] <= stk_data;
                sp <= sp + 5'd1;
            end else if (stk_pop) begin
                d1 <= mem[4'(sp - 5'd1)];
                sp <= sp - 5'd1;
            end
            v1 <= stk_pop;
            v2 <= v1;
            d2 <= d1;
        end
    end

    assign stk_rdata = v2 ? d2 : 8'hEE;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         exp_push_cyc;   // 0 = no push strobe expected
        int         exp_pop_cyc;    // 0 = no pop strobe expected
        logic [7:0] exp_push_data;
        logic [3:0] exp_level;      // level in C1
    } vec_t;

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] d,
                                input logic [7:0] ed, input logic ee,
                                input int lat, input int pc, input int oc,
                                input logic [7:0] pd, input logic [3:0] lv);
        vec_t v;
        v.op = op; v.data = d; v.exp_data = ed; v.exp_err = ee;
        v.exp_lat = lat; v.exp_push_cyc = pc; v.exp_pop_cyc = oc;
        v.exp_push_data = pd; v.exp_level = lv;
        return v;
    endfunction

    function automatic vec_t v_push(input logic [7:0] d, input logic [3:0] lv);
        return mk(2'b00, d, d, 1'b0, 1, 1, 0, d, lv);
    endfunction
    function automatic vec_t v_pop(input logic [7:0] e, input logic [3:0] lv);
        return mk(2'b01, 8'h00, e, 1'b0, 4, 0, 1, 8'h00, lv);
    endfunction
    function automatic vec_t v_err(input logic [1:0] op, input logic [7:0] d,
                                   input logic [3:0] lv);
        return mk(op, d, 8'h00, 1'b1, 1, 0, 0, 8'h00, lv);
    endfunction
    function automatic vec_t v_peek(input logic [7:0] e, input logic [3:0] lv);
        return mk(2'b10, 8'h00, e, 1'b0, 4, 4, 1, e, lv);
    endfunction

    // Issue one command with rsp_ready high and observe it to completion
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d,
                          output logic found, output logic [7:0] rdata,
                          output logic rerr, output int lat,
                          output int npush, output int npop,
                          output int push_cyc, output int pop_cyc,
                          output logic [7:0] push_data,
                          output logic [3:0] lvl1, output logic both);
        found = 1'b0; rdata = '0; rerr = 1'b0; lat = 0;
        npush = 0; npop = 0; push_cyc = 0; pop_cyc = 0;
        push_data = '0; lvl1 = '0; both = 1'b0;
        for (int n = 0; n < 20 && !cmd_ready; n++) tick();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
            if (cyc == 1) lvl1 = level;
            if (stk_push && stk_pop) both = 1'b1;
            if (stk_push) begin
                npush++; push_cyc = cyc; push_data = stk_data;
            end
            if (stk_pop) begin
                npop++; pop_cyc = cyc;
            end
            if (rsp_valid) begin
                found = 1'b1; rdata = rsp_data; rerr = rsp_err; lat = cyc;
            end
            tick();
        end
        // Cycle after the response handshake: no stray strobes
        if (stk_push) npush++;
        if (stk_pop)  npop++;
    endtask

    vec_t vecs[$];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       found, rerr, both;
        logic [7:0] rdata, pdata;
        logic [3:0] lvl1;
        int         lat, npush, npop, pcyc, ocyc;

        vecs.push_back(v_push(8'hA5, 4'd1));
        vecs.push_back(v_pop(8'hA5, 4'd0));
        vecs.push_back(v_push(8'h11, 4'd1));
        vecs.push_back(v_push(8'h22, 4'd2));
        vecs.push_back(v_pop(8'h22, 4'd1));
        vecs.push_back(v_pop(8'h11, 4'd0));
        vecs.push_back(v_err(2'b01, 8'h00, 4'd0));
        vecs.push_back(v_err(2'b11, 8'h44, 4'd0));
        vecs.push_back(v_push(8'h3C, 4'd1));
`ifdef STACK_SEQ_PEEK_EN
        vecs.push_back(v_peek(8'h3C, 4'd1));
`else
        vecs.push_back(v_err(2'b10, 8'h00, 4'd1));
`endif
        vecs.push_back(v_pop(8'h3C, 4'd0));
        vecs.push_back(v_err(2'b10, 8'h00, 4'd0));
        for (int k = 1; k <= 15; k++) vecs.push_back(v_push(8'(k), 4'(k)));
        vecs.push_back(v_err(2'b00, 8'h5A, 4'd15));
        vecs.push_back(v_pop(8'h0F, 4'd14));

        // Reset values
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 0, cmd_ready, 0);
        chk("rst_rsp_valid", 0, rsp_valid, 0);
        chk("rst_rsp_data",  0, rsp_data, 0);
        chk("rst_rsp_err",   0, rsp_err, 0);
        chk("rst_stk_push",  0, stk_push, 0);
        chk("rst_stk_pop",   0, stk_pop, 0);
        chk("rst_stk_data",  0, stk_data, 0);
        chk("rst_level",     0, level, 0);
        @(negedge clk) reset_n = 1'b1;
        tick(); tick();
        chk("post_rst_cmd_ready", 0, cmd_ready, 1);

        // Table-driven command sequence
        foreach (vecs[i]) begin
            do_cmd(vecs[i].op, vecs[i].data, found, rdata, rerr, lat,
                   npush, npop, pcyc, ocyc, pdata, lvl1, both);
            chk("rsp_seen",  i, found, 1);
            chk("rsp_data",  i, rdata, vecs[i].exp_data);
            chk("rsp_err",   i, rerr, vecs[i].exp_err);
            chk("rsp_lat",   i, lat, vecs[i].exp_lat);
            chk("n_push",    i, npush, (vecs[i].exp_push_cyc != 0) ? 1 : 0);
            chk("push_cyc",  i, pcyc, vecs[i].exp_push_cyc);
            chk("n_pop",     i, npop, (vecs[i].exp_pop_cyc != 0) ? 1 : 0);
            chk("pop_cyc",   i, ocyc, vecs[i].exp_pop_cyc);
            chk("level",     i, lvl1, vecs[i].exp_level);
            chk("no_overlap", i, both, 0);
            if (vecs[i].exp_push_cyc != 0)
                chk("push_data", i, pdata, vecs[i].exp_push_data);
        end

        // Response back-pressure: level 14 -> push 77 -> pop held 5 cycles
        do_cmd(2'b00, 8'h77, found, rdata, rerr, lat,
               npush, npop, pcyc, ocyc, pdata, lvl1, both);
        chk("bp_push_data", 0, rdata, 8'h77);
        chk("bp_push_level", 0, lvl1, 15);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        tick();
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            if (rsp_valid) found = 1'b1;
            else tick();
        end
        chk("bp_rsp_seen", 0, found, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", k, rsp_valid, 1);
            chk("bp_rsp_data",  k, rsp_data, 8'h77);
            chk("bp_rsp_err",   k, rsp_err, 0);
            chk("bp_cmd_ready", k, cmd_ready, 0);
            chk("bp_level",     k, level, 14);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_rsp_done",  0, rsp_valid, 0);
        chk("bp_cmd_ready_after", 0, cmd_ready, 1);
        chk("bp_level_after", 0, level, 14);

        // Reset asserted while a pop is in POP_WAIT
        do_cmd(2'b00, 8'h99, found, rdata, rerr, lat,
               npush, npop, pcyc, ocyc, pdata, lvl1, both);
        chk("ar_push_data", 0, rdata, 8'h99);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        tick();
        cmd_valid = 1'b0;
        chk("ar_pop_strobe", 0, stk_pop, 1);
        tick();
        chk("ar_in_wait", 0, rsp_valid, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_cmd_ready", 0, cmd_ready, 0);
        chk("ar_rsp_valid", 0, rsp_valid, 0);
        chk("ar_rsp_data",  0, rsp_data, 0);
        chk("ar_rsp_err",   0, rsp_err, 0);
        chk("ar_stk_push",  0, stk_push, 0);
        chk("ar_stk_pop",   0, stk_pop, 0);
        chk("ar_stk_data",  0, stk_data, 0);
        chk("ar_level",     0, level, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick(); tick();
        found = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (rsp_valid || stk_push || stk_pop) found = 1'b1;
            tick();
        end
        chk("ar_no_late_rsp", 0, found, 0);
        chk("ar_cmd_ready_after", 0, cmd_ready, 1);
        chk("ar_level_after", 0, level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
